timers_timer2_ocg: RTL
======================

# timers_timer2_ocg

Timer2 output compare generator: the transmit-side counterpart of the timer2 capture path. It produces a programmable periodic pulse train on a phase/tooth-style output from a 24-bit period and 16-bit pulse width held in SFRs. It raises a period flag and exposes the live counter for software. It sits in the timers subsystem next to the timer2 capture logic and drives an engine actuator pin or a loop-back phase input.

## Interface
- PER_W, 24: period counter width; split into three SFR bytes (H/M/L).
- WID_W, 16: pulse width width; split into two SFR bytes (H/L).
- timers_timer2_ocg_clock_i  in  1  system clock; all logic is rising-edge.
- timers_timer2_ocg_reset_i_b  in  1  asynchronous, active-low reset.
- timers_sfr_tcon3_tr3_i  in  1  run enable.
- timers_sfr_tcon3_pol_i  in  1  output polarity: 1 means the active level is high.
- timers_sfr_tocph_i / tocpm_i / tocpl_i  in  8 each  period P, in clocks.
- timers_sfr_tocwh_i / tocwl_i  in  8 each  active width W, in clocks.
- timers_sfr_toc_ld_i  in  1  one-cycle strobe that captures P and W into the shadow and sets load-pending.
- timers_sfr_tcon3_tf3_clr_i  in  1  one-cycle strobe that clears the period flag.
- timers_timer2_ocg_pht_o  out  1  generated waveform, registered.
- timers_sfr_tcon3_tf3_o  out  1  period flag, registered.
- timers_sfr_ocrh_o / ocrm_o / ocrl_o  out  8 each  current counter value, registered.

## Operation
- Registers:
  - Shadow: P_sh, W_sh, pend.
  - Active: P_act, W_act.
  - Counter: cnt (PER_W bits).
  - State and flag.
- States:
  - IDLE: tr3 = 0.
  - RUN
  - HALT: running with P_act = 0.
- IDLE:
  - cnt = 0; output inactive.
  - When tr3 = 1: if pend, copy the shadow to active and clear pend.
  - Next state is HALT if the resulting P_act = 0, else RUN with cnt = 0.
- RUN:
  - If cnt = P_act − 1 (wrap):
    - cnt ← 0 and flag ← 1.
    - If pend, apply the shadow and clear pend.
    - If the newly applied P = 0, go to HALT.
  - Otherwise cnt ← cnt + 1.
- HALT:
  - cnt = 0; output inactive; no flags.
  - When a load occurs, apply it immediately; go to RUN if P ≠ 0.
- From any state, tr3 = 0 sends the block to IDLE next cycle:
  - cnt cleared and output inactive.
  - Shadow and pend retained.
- Output: pht_o = pol when (state = RUN and cnt < W_act); otherwise pht_o = ~pol.
  - W = 0 gives a constant inactive level.
  - W ≥ P gives a constant active level; the flag still fires every period.
- A load strobe in the same cycle as a wrap is applied at that wrap, using the strobe-cycle SFR values.
- A second load before a wrap overwrites the shadow; there is no queue.
- Flag:
  - Set on a wrap.
  - Cleared by tf3_clr_i.
  - Set wins if both happen in the same cycle.
- A pol change takes effect on the next clock, and only the output level changes.
- Width rule: W_act is zero-extended to PER_W before comparison. cnt never exceeds P_act − 1.

## Timing
- Reset values:
  - pht_o = 0.
  - tf3_o = 0.
  - ocrh/m/l = 0x00.
  - state = IDLE.
  - P/W shadow and active = 0; pend = 0.
- Note: after reset, the inactive level (~pol) appears one clock later, once pol has been sampled.
- Start latency: tr3 is sampled high at edge k. The first RUN cycle (cnt = 0, output active if W > 0) is visible after edge k+1.
- Period is exactly P clocks. The active phase is W clocks starting at cnt = 0.
- tf3_o rises in the same cycle that cnt returns to 0.
- ocr outputs equal cnt in the same cycle: no extra latency.
- Stop latency is one clock after tr3 is sampled low.

## Structure
- Shared package timers_pkg holds:
  - state encoding: IDLE / RUN / HALT;
  - PER_W and WID_W defaults;
  - the byte-split helper constants.
- Sub-module timers_timer2_ocg_shadow holds the double buffer:
  - shadow registers and pend;
  - apply handshake: apply_i in, P_act/W_act out.
- The top holds the FSM, counter, comparator, flag and output registers.

## Test plan
- Reset, then P = 10, W = 3, pol = 1, load, tr3 = 1 → pht_o high for 3 clocks and low for 7; tf3_o rises every 10 clocks, first 10 clocks after the first active cycle.
- While running P = 10, load P = 4, W = 1 mid-period → the current 10-clock period completes, then 4-clock periods with a 1-clock pulse.
- Load strobe exactly on a wrap → new P/W are used for the immediately following period.
- P = 5, W = 8 → pht_o constantly high; tf3_o every 5 clocks. W = 0 → pht_o constantly low.
- tr3 dropped at cnt = 6 → one clock later cnt = 0 and pht_o inactive. Restarting resumes from cnt = 0.
- tf3_clr_i asserted in the wrap cycle → tf3_o = 1. Load P = 0 → HALT with no flag; loading P = 3 resumes 3-clock periods.

Source files
------------

// File: rtl/timers_pkg.sv
// Shared timers definitions: output-compare FSM encoding, default widths and SFR byte-split positions.
package timers_pkg;

   localparam int TMR_PER_W = 24;
   localparam int TMR_WID_W = 16;

   localparam int BYTE_W    = 8;
   localparam int PER_H_LSB = 16;
   localparam int PER_M_LSB = 8;
   localparam int PER_L_LSB = 0;
   localparam int WID_H_LSB = 8;
   localparam int WID_L_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } ocg_state_t;

endpackage

// File: rtl/timers_timer2_ocg_shadow.sv
// Period/width double buffer: a load lands in the shadow and sets pend; apply copies it to the active pair.
// Apply is registered (visible after the next edge); a load in the apply cycle bypasses the shadow. No backpressure.
module timers_timer2_ocg_shadow
   import timers_pkg::*;
#(
   parameter int PER_W = TMR_PER_W,
   parameter int WID_W = TMR_WID_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ld,
   input  logic [PER_W-1:0] i_per,
   input  logic [WID_W-1:0] i_wid,
   input  logic             i_apply,
   output logic             o_pend,
   output logic [PER_W-1:0] o_per_nxt,
   output logic [WID_W-1:0] o_wid_nxt,
   output logic [PER_W-1:0] o_per_act,
   output logic [WID_W-1:0] o_wid_act
);

   logic [PER_W-1:0] r_per_sh;
   logic [WID_W-1:0] r_wid_sh;
   logic             r_pend;
   logic [PER_W-1:0] r_per_act;
   logic [WID_W-1:0] r_wid_act;

   // A strobe in the apply cycle counts as pending and supplies the values directly
   assign o_pend    = r_pend | i_ld;
   assign o_per_nxt = i_ld ? i_per : r_per_sh;
   assign o_wid_nxt = i_ld ? i_wid : r_wid_sh;
   assign o_per_act = r_per_act;
   assign o_wid_act = r_wid_act;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_per_sh  <= '0;
         r_wid_sh  <= '0;
         r_pend    <= 1'b0;
         r_per_act <= '0;
         r_wid_act <= '0;
      end else begin
         if (i_ld) begin
            r_per_sh <= i_per;
            r_wid_sh <= i_wid;
         end
         if (i_apply) begin
            r_per_act <= o_per_nxt;
            r_wid_act <= o_wid_nxt;
            r_pend    <= 1'b0;
         end else if (i_ld) begin
            r_pend    <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/timers_timer2_ocg.sv
// Timer2 output compare generator: periodic pulse of W clocks every P clocks, period flag and live counter.
// Run enable is registered, so start/stop act one clock after tr3 is sampled; outputs are registered; no backpressure.
module timers_timer2_ocg
   import timers_pkg::*;
#(
   parameter int PER_W = TMR_PER_W,
   parameter int WID_W = TMR_WID_W
) (
   input  logic       timers_timer2_ocg_clock_i,
   input  logic       timers_timer2_ocg_reset_i_b,
   input  logic       timers_sfr_tcon3_tr3_i,
   input  logic       timers_sfr_tcon3_pol_i,
   input  logic [7:0] timers_sfr_tocph_i,
   input  logic [7:0] timers_sfr_tocpm_i,
   input  logic [7:0] timers_sfr_tocpl_i,
   input  logic [7:0] timers_sfr_tocwh_i,
   input  logic [7:0] timers_sfr_tocwl_i,
   input  logic       timers_sfr_toc_ld_i,
   input  logic       timers_sfr_tcon3_tf3_clr_i,
   output logic       timers_timer2_ocg_pht_o,
   output logic       timers_sfr_tcon3_tf3_o,
   output logic [7:0] timers_sfr_ocrh_o,
   output logic [7:0] timers_sfr_ocrm_o,
   output logic [7:0] timers_sfr_ocrl_o
);

   logic [PER_W-1:0] w_sfr_per;
   logic [WID_W-1:0] w_sfr_wid;
   logic             w_pend;
   logic [PER_W-1:0] w_per_nxt;
   logic [WID_W-1:0] w_wid_nxt;
   logic [PER_W-1:0] w_per_act;
   logic [WID_W-1:0] w_wid_act;

   logic             r_tr3;
   ocg_state_t       r_state;
   ocg_state_t       w_state_nxt;
   logic [PER_W-1:0] r_cnt;
   logic [PER_W-1:0] w_cnt_nxt;
   logic             r_pht;
   logic             r_tf3;

   logic             w_wrap;
   logic             w_apply;
   logic [PER_W-1:0] w_per_eff;
   logic [WID_W-1:0] w_wid_eff;
   logic             w_active_nxt;

   assign w_sfr_per = {timers_sfr_tocph_i, timers_sfr_tocpm_i, timers_sfr_tocpl_i};
   assign w_sfr_wid = {timers_sfr_tocwh_i, timers_sfr_tocwl_i};

   timers_timer2_ocg_shadow #(
      .PER_W (PER_W),
      .WID_W (WID_W)
   ) u_shadow (
      .i_clk     (timers_timer2_ocg_clock_i),
      .i_rst_n   (timers_timer2_ocg_reset_i_b),
      .i_ld      (timers_sfr_toc_ld_i),
      .i_per     (w_sfr_per),
      .i_wid     (w_sfr_wid),
      .i_apply   (w_apply),
      .o_pend    (w_pend),
      .o_per_nxt (w_per_nxt),
      .o_wid_nxt (w_wid_nxt),
      .o_per_act (w_per_act),
      .o_wid_act (w_wid_act)
   );

   // cnt stays below P_act while running, so equality is the only wrap test needed
   assign w_wrap  = r_tr3 && (r_state == ST_RUN) && (r_cnt == (w_per_act - PER_W'(1)));

   // Pending values are handed over on leaving IDLE, at a wrap, or as soon as they arrive in HALT
   assign w_apply = r_tr3 && w_pend &&
                    ((r_state == ST_IDLE) || (r_state == ST_HALT) || w_wrap);

   assign w_per_eff = w_apply ? w_per_nxt : w_per_act;
   assign w_wid_eff = w_apply ? w_wid_nxt : w_wid_act;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      if (!r_tr3) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = (w_per_eff == '0) ? ST_HALT : ST_RUN;
            end
            ST_RUN: begin
               if (w_wrap) begin
                  if (w_per_eff == '0) begin
                     w_state_nxt = ST_HALT;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + PER_W'(1);
               end
            end
            ST_HALT: begin
               if (w_per_eff != '0) begin
                  w_state_nxt = ST_RUN;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Output level is derived from the next count so the pin lines up with the ocr bytes
   assign w_active_nxt = (w_state_nxt == ST_RUN) && (w_cnt_nxt < PER_W'(w_wid_eff));

   always_ff @(posedge timers_timer2_ocg_clock_i or negedge timers_timer2_ocg_reset_i_b) begin
      if (!timers_timer2_ocg_reset_i_b) begin
         r_tr3   <= 1'b0;
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_pht   <= 1'b0;
         r_tf3   <= 1'b0;
      end else begin
         r_tr3   <= timers_sfr_tcon3_tr3_i;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pht   <= w_active_nxt ? timers_sfr_tcon3_pol_i : ~timers_sfr_tcon3_pol_i;
         if (w_wrap) begin
            r_tf3 <= 1'b1;
         end else if (timers_sfr_tcon3_tf3_clr_i) begin
            r_tf3 <= 1'b0;
         end
      end
   end

   assign timers_timer2_ocg_pht_o = r_pht;
   assign timers_sfr_tcon3_tf3_o  = r_tf3;
   assign timers_sfr_ocrh_o       = r_cnt[PER_H_LSB +: BYTE_W];
   assign timers_sfr_ocrm_o       = r_cnt[PER_M_LSB +: BYTE_W];
   assign timers_sfr_ocrl_o       = r_cnt[PER_L_LSB +: BYTE_W];

endmodule
